// File: rtl/aes_pkg.sv
// Shared AES definitions: mode encoding, parameter limits and GF(2^8) helpers.
package aes_pkg;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  localparam int LANES_MIN = 1;
  localparam int LANES_MAX = 16;
  localparam int TAG_W_MIN = 1;
  localparam int TAG_W_MAX = 8;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as AES requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] r;
    t = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r;
  endfunction

  // Forward affine transform of the S-box.
  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Inverse affine transform, undoes affine().
  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One byte lane: AES forward or inverse S-box, purely combinational.
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic       mode_i,
  output logic [7:0] data_o
);

  // Forward: inverse then affine; inverse: undo affine then inverse.
  always_comb begin
    data_o = 8'h00;
    if (mode_i == MODE_INV) data_o = gf_inv(inv_affine(data_i));
    else                    data_o = affine(gf_inv(data_i));
  end

endmodule

// File: rtl/aes_sub_bytes_pipe.sv
// Two-stage valid/ready SubBytes pipeline with per-beat mode and sideband tag.
// S1 registers the raw beat, the lane S-boxes sit between S1 and S2, S2 drives out_*.
module aes_sub_bytes_pipe
  import aes_pkg::*;
#(
  parameter int LANES = 4,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [8*LANES-1:0] in_data,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  if (LANES < LANES_MIN || LANES > LANES_MAX) begin : g_bad_lanes
    $error("aes_sub_bytes_pipe: LANES out of legal range");
  end
  if (TAG_W < TAG_W_MIN || TAG_W > TAG_W_MAX) begin : g_bad_tag_w
    $error("aes_sub_bytes_pipe: TAG_W out of legal range");
  end

  logic               s1_vld_q,  s1_vld_d;
  logic               s1_mode_q, s1_mode_d;
  logic [8*LANES-1:0] s1_data_q, s1_data_d;
  logic [TAG_W-1:0]   s1_tag_q,  s1_tag_d;
  logic               s2_vld_q,  s2_vld_d;
  logic [8*LANES-1:0] s2_data_q, s2_data_d;
  logic [TAG_W-1:0]   s2_tag_q,  s2_tag_d;
  logic [8*LANES-1:0] sub_data;
  logic               s1_load;
  logic               s2_load;

  // S2 takes S1 whenever it is empty or its current beat is leaving.
  assign s2_load  = s1_vld_q && (!s2_vld_q || out_ready);
  // Never looks at in_valid, so no combinational path in_valid -> in_ready.
  assign in_ready = !s1_vld_q || s2_load;
  assign s1_load  = in_valid && in_ready;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox_lane u_lane (
      .data_i (s1_data_q[8*g +: 8]),
      .mode_i (s1_mode_q),
      .data_o (sub_data[8*g +: 8])
    );
  end

  // Next-state for both stages; data registers only move on a load.
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_mode_d = s1_mode_q;
    s1_data_d = s1_data_q;
    s1_tag_d  = s1_tag_q;
    s2_vld_d  = s2_vld_q;
    s2_data_d = s2_data_q;
    s2_tag_d  = s2_tag_q;
    if (s1_load) begin
      s1_vld_d  = 1'b1;
      s1_mode_d = in_mode;
      s1_data_d = in_data;
      s1_tag_d  = in_tag;
    end else if (s2_load) begin
      s1_vld_d  = 1'b0;
    end
    if (s2_load) begin
      s2_vld_d  = 1'b1;
      s2_data_d = sub_data;
      s2_tag_d  = s1_tag_q;
    end else if (out_ready) begin
      s2_vld_d  = 1'b0;
    end
  end

  // Stage registers; reset drops any held beats and zeroes the output bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s1_mode_q <= MODE_FWD;
      s1_data_q <= '0;
      s1_tag_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_tag_q  <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_mode_q <= s1_mode_d;
      s1_data_q <= s1_data_d;
      s1_tag_q  <= s1_tag_d;
      s2_vld_q  <= s2_vld_d;
      s2_data_q <= s2_data_d;
      s2_tag_q  <= s2_tag_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign out_data  = s2_data_q;
  assign out_tag   = s2_tag_q;
  assign busy      = s1_vld_q | s2_vld_q;

endmodule

// File: tb/tb_aes_sub_bytes_pipe.sv
// Directed and stress bench for aes_sub_bytes_pipe (LANES=4, TAG_W=4).
module tb_aes_sub_bytes_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_mode;
  logic [31:0] in_data, out_data;
  logic [3:0]  in_tag, out_tag;
  logic        out_valid, out_ready, busy;

  aes_sub_bytes_pipe #(.LANES(4), .TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [3:0] tag; } exp_t;
  typedef struct { logic mode; logic [31:0] din; logic [3:0] tag; logic [31:0] dexp; } vec_t;

  exp_t        exp_q[$];
  vec_t        vt[18];
  int          checks = 0;
  int          errors = 0;
  bit          capture = 0;
  bit          push_en = 0;
  logic [31:0] cur_exp;
  bit          acc, s_in_ready, s_out_valid, s_busy;
  logic [31:0] s_out_data;
  logic [3:0]  s_out_tag;
  logic [31:0] cap[64], src_w[64], exp_w[64], orig[64];
  int          cap_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sample at the falling edge, then step to just after the next rising edge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_out_tag   = out_tag;
    s_busy      = busy;
    acc = !reset && in_valid && in_ready;
    if (acc && push_en) exp_q.push_back('{cur_exp, in_tag});
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", out_data, 32'hxxxxxxxx);
      end else begin
        e = exp_q.pop_front();
        if (capture) begin
          check("fwd_pass_tag", {28'd0, out_tag}, {28'd0, e.tag});
          if (cap_n < 64) cap[cap_n] = out_data;
          cap_n++;
        end else begin
          check("out_beat", {out_data[27:0], out_tag}, {e.data[27:0], e.tag});
          check("out_beat_hi", {28'd0, out_data[31:28]}, {28'd0, e.data[31:28]});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin cyc(); n++; end
    check("drain_done", exp_q.size(), 0);
  endtask

  task automatic stream(input logic mode, input bit rnd);
    int idx = 0;
    int budget = 3000;
    while ((idx < 64 || exp_q.size() != 0) && budget > 0) begin
      if (!in_valid && idx < 64 && (!rnd || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1; in_mode = mode; in_data = src_w[idx];
        in_tag = idx[3:0]; cur_exp = exp_w[idx];
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      if (acc) begin idx++; in_valid = 1'b0; end
      budget--;
    end
    check("stream_timeout", budget > 0, 1);
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    logic [31:0] w[4], f[4];
    int k, cnt;
    w[0] = 32'h03020100; f[0] = 32'h7B777C63;
    w[1] = 32'h07060504; f[1] = 32'hC56F6BF2;
    w[2] = 32'h0B0A0908; f[2] = 32'h2B670130;
    w[3] = 32'h0F0E0D0C; f[3] = 32'h76ABD7FE;
    vt[0] = '{1'b0, 32'h530100FF, 4'h1, 32'hED7C6316};
    vt[1] = '{1'b1, 32'h6352007D, 4'hA, 32'h00485213};
    for (int i = 2; i < 18; i++) begin
      k = ((i - 2) / 2) % 4;
      if (i % 2 == 0) vt[i] = '{1'b0, w[k], 4'(i), f[k]};
      else            vt[i] = '{1'b1, f[k], 4'(i), w[k]};
    end

    // Reset values
    reset = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; in_tag = '0;
    out_ready = 1'b1; cur_exp = '0;
    @(posedge clk); #1;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    check("rst_out_valid", s_out_valid, 0);
    check("rst_busy", s_busy, 0);
    check("rst_in_ready", s_in_ready, 1);
    check("rst_out_data", s_out_data, 0);
    check("rst_out_tag", s_out_tag, 0);

    // Table vectors back to back, alternating mode, counting output cycles
    push_en = 1'b1; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 18) begin
        in_valid = 1'b1; in_mode = vt[i].mode; in_data = vt[i].din;
        in_tag = vt[i].tag; cur_exp = vt[i].dexp;
      end else in_valid = 1'b0;
      cyc();
      if (i < 18) check("b2b_in_ready", s_in_ready, 1);
      if (s_out_valid) cnt++;
    end
    check("b2b_no_bubble", cnt, 18);
    drain(10);

    // Latency: visible exactly two cycles after the transfer cycle
    in_valid = 1'b1; in_mode = 1'b0; in_data = 32'h530100FF; in_tag = 4'h5;
    cur_exp = 32'hED7C6316;
    cyc();
    check("lat_accept", acc, 1);
    in_valid = 1'b0;
    check("lat_c0", s_out_valid, 0);
    cyc();
    check("lat_c1", s_out_valid, 0);
    cyc();
    check("lat_c2", s_out_valid, 1);
    check("lat_data", s_out_data, 32'hED7C6316);
    check("lat_tag", s_out_tag, 4'h5);

    // Backpressure: 3 beats offered for 5 stalled cycles
    out_ready = 1'b0; k = 0;
    for (int c = 0; c < 5; c++) begin
      if (k < 3) begin
        in_valid = 1'b1;
        case (k)
          0: begin in_mode = 1'b0; in_data = w[0]; in_tag = 4'h1; cur_exp = f[0]; end
          1: begin in_mode = 1'b1; in_data = f[1]; in_tag = 4'h2; cur_exp = w[1]; end
          default: begin in_mode = 1'b0; in_data = w[2]; in_tag = 4'h3; cur_exp = f[2]; end
        endcase
      end
      cyc();
      if (acc) k++;
      if (c >= 2) check("bp_hold_data", s_out_data, f[0]);
    end
    check("bp_accepted", k, 2);
    check("bp_in_ready_low", s_in_ready, 0);
    out_ready = 1'b1;
    cnt = 0;
    while (k < 3 && cnt < 20) begin cyc(); if (acc) k++; cnt++; end
    in_valid = 1'b0;
    check("bp_third_accept", k, 3);
    drain(10);

    // Reset with both stages full discards everything
    push_en = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 1'b0; in_data = w[3]; in_tag = 4'h7;
    cyc(); cyc();
    in_valid = 1'b0; reset = 1'b1;
    cyc();
    check("full_busy", s_busy, 1);
    check("full_in_ready", s_in_ready, 0);
    reset = 1'b0; exp_q.delete();
    cyc();
    check("mid_rst_out_valid", s_out_valid, 0);
    check("mid_rst_busy", s_busy, 0);
    check("mid_rst_in_ready", s_in_ready, 1);
    check("mid_rst_out_data", s_out_data, 0);
    out_ready = 1'b1; cnt = 0;
    for (int c = 0; c < 5; c++) begin cyc(); if (s_out_valid) cnt++; end
    check("no_stale_beat", cnt, 0);

    // Random stress: all 256 bytes forward, then back through inverse
    push_en = 1'b1;
    for (int b = 0; b < 64; b++) begin
      orig[b]  = {8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)};
      src_w[b] = orig[b];
      exp_w[b] = '0;
    end
    capture = 1'b1; cap_n = 0;
    stream(1'b0, 1'b1);
    capture = 1'b0;
    check("fwd_pass_count", cap_n, 64);
    check("fwd_pass_00", cap[0], f[0]);
    for (int b = 0; b < 64; b++) begin src_w[b] = cap[b]; exp_w[b] = orig[b]; end
    stream(1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_sub_bytes_pipe.md
AES_SUB_BYTES_PIPE -- requirements
Module: aes_sub_bytes_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning byte lanes substituted per beat (legal 1..16).
REQ-002 SHALL have parameter TAG_W, default 4, meaning width of the sideband tag carried with each beat (legal 1..8).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  input beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts the beat this cycle.
REQ-007 SHALL have port in_mode  input  1  0 = forward S-box, 1 = inverse S-box, per beat.
REQ-008 SHALL have port in_data  input  8*LANES  bytes; lane k = bits [8k+7:8k].
REQ-009 SHALL have port in_tag  input  TAG_W  opaque sideband, returned unchanged.
REQ-010 SHALL have port out_valid  output  1  output beat present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the beat.
REQ-012 SHALL have port out_data  output  8*LANES  substituted bytes, lane-aligned with in_data.
REQ-013 SHALL have port out_tag  output  TAG_W  tag of the beat on out_data.
REQ-014 SHALL have port busy  output  1  high while any beat is held internally.

Function
REQ-015 Beat transfer SHALL occur on any cycle with valid and ready both high, on both ports.
REQ-016 Each lane SHALL map its byte through the AES forward S-box (in_mode=0) or inverse S-box (in_mode=1); lanes independent.
REQ-017 The pipeline SHALL have two register stages: S1 captures in_data/in_mode/in_tag on input transfer; S2 holds the substituted result driving out_*.
REQ-018 Latency SHALL be exactly 2 cycles from input transfer to out_valid when out_ready is held high.
REQ-019 Throughput SHALL be one beat per cycle with out_ready held high.
REQ-020 S2 SHALL load from S1 when S1 valid and (S2 empty or out_ready); S1 SHALL load when in_valid and in_ready.
REQ-021 in_ready SHALL be high when S1 is empty or S1 advances into S2 in the same cycle; it SHALL be combinational only from out_ready and internal state, never from in_valid.
REQ-022 While out_valid is high and out_ready low, out_data and out_tag SHALL hold stable.
REQ-023 Mode SHALL travel with its beat; consecutive beats with differing modes SHALL each be substituted in their own mode.
REQ-024 With both stages full and out_ready low, in_ready SHALL be low and no beat SHALL be dropped or duplicated.
REQ-025 Simultaneous input transfer and output transfer with both stages full SHALL shift the pipeline with no bubble.
REQ-026 busy SHALL equal S1 valid OR S2 valid.

Reset
REQ-027 Reset SHALL clear S1 and S2 valid flags; out_valid=0, busy=0, in_ready=1 on the first cycle after reset.
REQ-028 out_data and out_tag SHALL reset to all-zero.
REQ-029 Reset asserted mid-operation SHALL discard all held beats; none SHALL appear at the output afterwards.

Structure
REQ-030 Mode encoding (FWD=0, INV=1) and the LANES/TAG_W legal limits SHALL live in the shared package aes_pkg.
REQ-031 One sub-module aes_sbox_lane (8-bit in, mode in, 8-bit out, purely combinational, forward and inverse tables) SHALL be instantiated LANES times between S1 and S2.
REQ-032 Elaboration SHALL fail on LANES or TAG_W outside legal range.

Verification
REQ-033 LANES=4, forward, in_data=32'h53_01_00_FF, out_ready=1 -> 2 cycles later out_data=32'hED_7C_63_16.
REQ-034 Inverse, in_data=32'h63_52_00_7D -> out_data=32'h00_48_52_13; tag 4'hA returned as 4'hA.
REQ-035 Alternating mode every beat, 16 back-to-back beats, out_ready=1 -> 16 outputs, in order, each correct, no bubbles after fill.
REQ-036 out_ready=0 for 5 cycles with 3 beats offered -> exactly 2 accepted, in_ready low, out_data stable; release -> 3 beats delivered in order.
REQ-037 Reset asserted with both stages full -> next cycle out_valid=0, busy=0, in_ready=1, no stale beat emitted.
REQ-038 Random valid/ready stress with forward-then-inverse scoreboard over all 256 byte values -> round-trip identity per lane.
